// File: rtl/logic_gate.sv
// Registered two-operand bitwise logic unit: seven gate results one cycle after capture.
// Optional accepted-vector counter on vec_cnt when LOGIC_GATE_CNT_EN is defined.
module logic_gate #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y1,
  output logic [WIDTH-1:0] y2,
  output logic [WIDTH-1:0] y3,
  output logic [WIDTH-1:0] y4,
  output logic [WIDTH-1:0] y5,
  output logic [WIDTH-1:0] y6,
  output logic [WIDTH-1:0] y7,
`ifdef LOGIC_GATE_CNT_EN
  output logic [15:0]      vec_cnt,
`endif
  output logic             out_valid
);

  logic [WIDTH-1:0] and_p1, or_p1, nand_p1, nor_p1, xor_p1, xnor_p1, not_p1;
  logic             vld_p1;

  // Stage p0 -> p1: capture gate results only on accepted vectors so that
  // operand changes (including X) outside in_valid never reach the outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_p1  <= 1'b0;
      and_p1  <= '0;
      or_p1   <= '0;
      nand_p1 <= '0;
      nor_p1  <= '0;
      xor_p1  <= '0;
      xnor_p1 <= '0;
      not_p1  <= '0;
    end else begin
      vld_p1 <= in_valid;
      if (in_valid) begin
        and_p1  <= a & b;
        or_p1   <= a | b;
        nand_p1 <= ~(a & b);
        nor_p1  <= ~(a | b);
        xor_p1  <= a ^ b;
        xnor_p1 <= ~(a ^ b);
        not_p1  <= ~a;
      end
    end
  end

  assign y1        = and_p1;
  assign y2        = or_p1;
  assign y3        = nand_p1;
  assign y4        = nor_p1;
  assign y5        = xor_p1;
  assign y6        = xnor_p1;
  assign y7        = not_p1;
  assign out_valid = vld_p1;

`ifdef LOGIC_GATE_CNT_EN
  logic [15:0] cnt_p1;

  // Stage p0 -> p1: saturating count of accepted vectors.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_p1 <= '0;
    end else if (in_valid && (cnt_p1 != 16'hFFFF)) begin
      cnt_p1 <= cnt_p1 + 16'd1;
    end
  end

  assign vec_cnt = cnt_p1;
`endif

endmodule

// File: tb/tb_logic_gate.sv
// Randomized self-checking bench for logic_gate; a WIDTH=1 and a WIDTH=8 instance share control.
// Counter checks are compiled in only when LOGIC_GATE_CNT_EN is defined.
module tb_logic_gate;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic [0:0] a1, b1;
  logic [7:0] a8, b8;
  logic [0:0] w1_y1, w1_y2, w1_y3, w1_y4, w1_y5, w1_y6, w1_y7;
  logic [7:0] w8_y1, w8_y2, w8_y3, w8_y4, w8_y5, w8_y6, w8_y7;
  logic       w1_vld, w8_vld;
`ifdef LOGIC_GATE_CNT_EN
  logic [15:0] w1_cnt, w8_cnt;
`endif

  int checks = 0;
  int errors = 0;

  logic [63:0] exp1 [1:7];
  logic [63:0] exp8 [1:7];
  logic        evld;
  logic [15:0] ecnt;
  logic [63:0] obs1 [1:7];
  logic [63:0] obs8 [1:7];

  always #5 clk = ~clk;

  logic_gate #(.WIDTH(1)) u_w1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a1), .b(b1),
    .y1(w1_y1), .y2(w1_y2), .y3(w1_y3), .y4(w1_y4), .y5(w1_y5), .y6(w1_y6), .y7(w1_y7),
`ifdef LOGIC_GATE_CNT_EN
    .vec_cnt(w1_cnt),
`endif
    .out_valid(w1_vld)
  );

  logic_gate #(.WIDTH(8)) u_w8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a8), .b(b8),
    .y1(w8_y1), .y2(w8_y2), .y3(w8_y3), .y4(w8_y4), .y5(w8_y5), .y6(w8_y6), .y7(w8_y7),
`ifdef LOGIC_GATE_CNT_EN
    .vec_cnt(w8_cnt),
`endif
    .out_valid(w8_vld)
  );

  always_comb begin
    obs1[1] = 64'(w1_y1); obs1[2] = 64'(w1_y2); obs1[3] = 64'(w1_y3); obs1[4] = 64'(w1_y4);
    obs1[5] = 64'(w1_y5); obs1[6] = 64'(w1_y6); obs1[7] = 64'(w1_y7);
    obs8[1] = 64'(w8_y1); obs8[2] = 64'(w8_y2); obs8[3] = 64'(w8_y3); obs8[4] = 64'(w8_y4);
    obs8[5] = 64'(w8_y5); obs8[6] = 64'(w8_y6); obs8[7] = 64'(w8_y7);
  end

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Gate k of the truth set, masked to w bits.
  function automatic logic [63:0] gate(input int k, input logic [63:0] x, input logic [63:0] y,
                                       input int w);
    logic [63:0] r;
    case (k)
      1:       r = x & y;
      2:       r = x | y;
      3:       r = ~(x & y);
      4:       r = ~(x | y);
      5:       r = x ^ y;
      6:       r = ~(x ^ y);
      default: r = ~x;
    endcase
    return r & ((64'd1 << w) - 64'd1);
  endfunction

  task automatic model_step();
    if (!rst_n) begin
      for (int k = 1; k <= 7; k++) begin exp1[k] = '0; exp8[k] = '0; end
      evld = 1'b0;
      ecnt = '0;
    end else if (in_valid) begin
      for (int k = 1; k <= 7; k++) begin
        exp1[k] = gate(k, 64'(a1), 64'(b1), 1);
        exp8[k] = gate(k, 64'(a8), 64'(b8), 8);
      end
      evld = 1'b1;
      if (ecnt != 16'hFFFF) ecnt = ecnt + 16'd1;
    end else begin
      evld = 1'b0;
    end
  endtask

  task automatic check_all(input string ph);
    for (int k = 1; k <= 7; k++) begin
      check_eq($sformatf("%s_w1_y%0d", ph, k), obs1[k], exp1[k]);
      check_eq($sformatf("%s_w8_y%0d", ph, k), obs8[k], exp8[k]);
    end
    check_eq({ph, "_w1_vld"}, 64'(w1_vld), 64'(evld));
    check_eq({ph, "_w8_vld"}, 64'(w8_vld), 64'(evld));
`ifdef LOGIC_GATE_CNT_EN
    check_eq({ph, "_w1_cnt"}, 64'(w1_cnt), 64'(ecnt));
    check_eq({ph, "_w8_cnt"}, 64'(w8_cnt), 64'(ecnt));
`endif
  endtask

  // One clock: advance the model on the inputs present at the edge, then sample.
  task automatic cyc(input string ph);
    @(posedge clk);
    model_step();
    #1;
    check_all(ph);
  endtask

  logic [1:0] tv_ab  [4];
  logic [6:0] tv_out [4];

  initial begin
    tv_ab[0] = 2'b00; tv_out[0] = 7'b0011011;
    tv_ab[1] = 2'b01; tv_out[1] = 7'b0110101;
    tv_ab[2] = 2'b10; tv_out[2] = 7'b0110100;
    tv_ab[3] = 2'b11; tv_out[3] = 7'b1100010;
    for (int k = 1; k <= 7; k++) begin exp1[k] = '0; exp8[k] = '0; end
    evld = 1'b0;
    ecnt = '0;

    // Reset held with a live vector presented.
    rst_n = 1'b0; in_valid = 1'b1; a1 = 1'b1; b1 = 1'b1; a8 = 8'hFF; b8 = 8'hFF;
    cyc("rst0");
    cyc("rst1");
    check_eq("rst_w1_zero", 64'({w1_y1, w1_y2, w1_y3, w1_y4, w1_y5, w1_y6, w1_y7, w1_vld}), 64'd0);

    // Truth table, plus the 8-bit reference vector on the first row.
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      a1 = tv_ab[i][1]; b1 = tv_ab[i][0];
      a8 = (i == 0) ? 8'hF0 : 8'(($urandom));
      b8 = (i == 0) ? 8'hCC : 8'(($urandom));
      cyc($sformatf("tt%0d", i));
      check_eq($sformatf("tt%0d_const", i),
               64'({w1_y1, w1_y2, w1_y3, w1_y4, w1_y5, w1_y6, w1_y7}), 64'(tv_out[i]));
      if (i == 0)
        check_eq("wide_const", {8'h0, w8_y1, w8_y2, w8_y3, w8_y4, w8_y5, w8_y6, w8_y7},
                 {8'h0, 8'hC0, 8'hFC, 8'h3F, 8'h03, 8'h3C, 8'hC3, 8'h0F});
    end

    // Hold: operands toggle while in_valid is low.
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      a1 = ~a1; b1 = ~b1; a8 = ~a8; b8 = 8'($urandom);
      cyc("hold");
    end
    check_eq("hold_const", 64'({w1_y1, w1_y2, w1_y3, w1_y4, w1_y5, w1_y6, w1_y7, w1_vld}),
             64'({7'b1100010, 1'b0}));

    // Reset mid-stream drops the vector on the reset edge.
    in_valid = 1'b1; a1 = 1'b1; b1 = 1'b1; a8 = 8'h5A; b8 = 8'hA5;
    cyc("pre");
    rst_n = 1'b0; a1 = 1'b0; b1 = 1'b1;
    cyc("mid_rst");
    check_eq("mid_rst_vld", 64'(w1_vld), 64'd0);
    rst_n = 1'b1; a1 = 1'b1; b1 = 1'b0;
    cyc("resume");
    check_eq("resume_y2", 64'(w1_y2), 64'd1);
    check_eq("resume_y7", 64'(w1_y7), 64'd0);

    // Randomized traffic with occasional reset.
    for (int i = 0; i < 300; i++) begin
      rst_n    = ($urandom_range(0, 29) != 0);
      in_valid = ($urandom_range(0, 2) != 0);
      a1 = 1'($urandom); b1 = 1'($urandom);
      a8 = 8'($urandom); b8 = 8'($urandom);
      cyc("rand");
    end

`ifdef LOGIC_GATE_CNT_EN
    rst_n = 1'b0; in_valid = 1'b0;
    cyc("cnt_rst");
    rst_n = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) cyc("cnt3");
    check_eq("cnt_three", 64'(w8_cnt), 64'd3);
    for (int i = 0; i < 65534; i++) begin
      @(posedge clk);
      model_step();
    end
    #1;
    check_eq("cnt_sat_reach", 64'(w8_cnt), 64'hFFFF);
    cyc("cnt_sat");
    cyc("cnt_sat2");
    check_eq("cnt_sat_hold", 64'(w1_cnt), 64'hFFFF);
    rst_n = 1'b0;
    cyc("cnt_clr");
    check_eq("cnt_clear", 64'(w8_cnt), 64'd0);
    rst_n = 1'b1;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/logic_gate.md
# logic_gate

Registered two-operand bitwise logic unit. Each accepted operand pair (a, b) produces seven gate results (AND, OR, NAND, NOR, XOR, XNOR, NOT a) on dedicated outputs, one clock after capture. Used as a leaf primitive wherever a full set of bitwise combinations of two vectors is needed in one cycle. Results hold between accepted inputs.

## Interface
- WIDTH, 1: bit width of operands and of every result output; legal range 1–64.
- clk  input  1  rising-edge clock for all state.
- rst_n  input  1  synchronous active-low reset, sampled on the rising edge of clk.
- in_valid  input  1  high = a/b captured this edge.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- y1  output  WIDTH  a & b.
- y2  output  WIDTH  a | b.
- y3  output  WIDTH  ~(a & b).
- y4  output  WIDTH  ~(a | b).
- y5  output  WIDTH  a ^ b.
- y6  output  WIDTH  ~(a ^ b).
- y7  output  WIDTH  ~a (b ignored).
- out_valid  output  1  high for one cycle after each accepted input.
- vec_cnt  output  16  accepted-vector count; present only with LOGIC_GATE_CNT_EN.
- Ports connect by name.

## Operation
- All gate functions are bitwise per bit index. There is no cross-bit interaction.
- Rising edge with rst_n=1 and in_valid=1:
  - y1..y7 load the functions of the current a/b.
  - out_valid <= 1.
- Rising edge with rst_n=1 and in_valid=0:
  - y1..y7 hold their previous value.
  - out_valid <= 0.
- a/b changes while in_valid=0 have no effect on any output.
- Rising edge with rst_n=0:
  - y1..y7 <= all zeros.
  - out_valid <= 0.
  - vec_cnt <= 0.
  - Reset overrides in_valid on that edge.
- No back-pressure. Every in_valid pulse is accepted.
- Back-to-back in_valid produces back-to-back out_valid.
- X/Z on a/b while in_valid=0 must not propagate to the outputs.

## Timing
- Latency: 1 cycle from the capturing edge to the result on y1..y7.
- out_valid coincides with the updated results.
- Throughput: one vector per cycle.
- All outputs are driven directly from flops. There is no combinational path from inputs to outputs.
- Reset takes effect on the first clk edge with rst_n low. Outputs hold 0 until the first accepted vector after rst_n rises.
- Reset asserted mid-stream: the vector presented on the reset edge is dropped. Its out_valid never appears.

## Configuration
- LOGIC_GATE_CNT_EN defined:
  - Adds the vec_cnt output.
  - vec_cnt increments by 1 on every accepted vector.
  - vec_cnt saturates at 16'hFFFF and does not wrap.
  - vec_cnt clears on reset.
- LOGIC_GATE_CNT_EN not defined:
  - The vec_cnt port and its counter logic are absent.
  - All other behaviour is identical.

## Test plan
- Reset, WIDTH=1: hold rst_n=0 for 2 edges with in_valid=1, a=1, b=1 -> y1..y7=0 and out_valid=0 throughout.
- Truth table, WIDTH=1: apply one vector per cycle with in_valid=1. The results below appear one cycle later, listed as y1..y7:
  - (a,b)=(0,0) -> 0,0,1,1,0,1,1
  - (0,1) -> 0,1,1,0,1,0,1
  - (1,0) -> 0,1,1,0,1,0,0
  - (1,1) -> 1,1,0,0,0,1,0
- Hold: after accepting (1,1), drop in_valid and toggle a/b for 5 cycles -> y1..y7 stay 1,1,0,0,0,1,0 and out_valid=0.
- Wide vectors, WIDTH=8: a=8'hF0, b=8'hCC ->
  - y1=C0, y2=FC, y3=3F, y4=03
  - y5=3C, y6=C3, y7=0F
- Reset mid-stream: assert rst_n=0 on the edge where in_valid=1 -> no out_valid next cycle, outputs 0. Resume with (1,0) -> y2=1, y7=0 one cycle later.
- Counter, LOGIC_GATE_CNT_EN: send 3 vectors -> vec_cnt=3. Force the count to FFFF and send 1 more vector -> vec_cnt stays FFFF. Reset -> vec_cnt=0.
